// File: rtl/tx_fifo_axis.sv
// AXI4-Lite register-fed transmit FIFO emitting words on an AXI4-Stream master.
// Words written to TXDATA/TXLAST are queued first-word-fall-through; STATUS and CTRL give level, flush and overflow control.
`timescale 1ns/1ps
module tx_fifo_axis #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_TXLAST = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                  en_q;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic                  aw_hs_s;
    logic                  ar_hs_s;
    logic [1:0]            wsel_s;
    logic [1:0]            rsel_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_req_s;
    logic                  push_ok_s;
    logic                  ovf_evt_s;
    logic                  ctrl_wr_s;
    logic                  flush_s;
    logic                  clr_ovf_s;
    logic                  pop_s;
    logic [31:0]           count_ext_s;
    logic [DATA_WIDTH-1:0] status_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  unused_s;

    assign unused_s = ^{s_axi_wstrb, s_axi_awaddr, s_axi_araddr};

    // Ready strobes are combinational on the handshake, so en_q holds them low through and just after reset
    assign aw_hs_s = en_q & (w_state_q == W_IDLE) & s_axi_awvalid & s_axi_wvalid;
    assign ar_hs_s = en_q & (r_state_q == R_IDLE) & s_axi_arvalid & ~rvalid_q;
    assign wsel_s  = s_axi_awaddr[3:2];
    assign rsel_s  = s_axi_araddr[3:2];

    assign full_s     = (count_q == CW'(DEPTH));
    assign empty_s    = (count_q == '0);
    assign push_req_s = aw_hs_s & ((wsel_s == REG_TXDATA) | (wsel_s == REG_TXLAST));
    assign push_ok_s  = push_req_s & ~full_s;
    assign ovf_evt_s  = push_req_s & full_s;
    assign ctrl_wr_s  = aw_hs_s & (wsel_s == REG_CTRL);
    assign flush_s    = ctrl_wr_s & s_axi_wdata[0];
    assign clr_ovf_s  = ctrl_wr_s & s_axi_wdata[1];
    assign pop_s      = ~empty_s & m_axis_tready;

    assign s_axi_awready = aw_hs_s;
    assign s_axi_wready  = aw_hs_s;
    assign s_axi_arready = ar_hs_s;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;

    assign m_axis_tvalid = ~empty_s;
    assign m_axis_tdata  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign m_axis_tlast  = mem_q[rd_ptr_q][DATA_WIDTH];
    assign overflow      = ovf_q;

    // STATUS word; level field holds the low 8 bits of the count
    always_comb begin
        count_ext_s    = 32'(count_q);
        status_s       = '0;
        status_s[0]    = empty_s;
        status_s[1]    = full_s;
        status_s[2]    = ovf_q;
        status_s[15:8] = count_ext_s[7:0];
    end

    // Read-data mux: only STATUS returns content
    always_comb begin
        rd_word_s = '0;
        case (rsel_s)
            REG_STATUS: rd_word_s = status_s;
            default:    rd_word_s = '0;
        endcase
    end

    // Write-channel FSM next state and B response
    always_comb begin
        w_state_d = w_state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = ovf_evt_s ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
                bresp_d   = RESP_OKAY;
            end
        endcase
    end

    // Read-channel FSM next state and R data capture
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word_s;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
                rdata_d   = '0;
            end
        endcase
    end

    // FIFO pointer/count/overflow next state; flush discards a same-cycle pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push_ok_s);
            rd_ptr_d = rd_ptr_q + PW'(pop_s);
            count_d  = count_q + CW'(push_ok_s) - CW'(pop_s);
        end
        if (ovf_evt_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            en_q      <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage array; entries carry {tlast, data}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= {(wsel_s == REG_TXLAST), s_axi_wdata};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_tx_fifo_axis.sv
// Randomized scoreboard bench for tx_fifo_axis: a queue-based model predicts beats, B responses and STATUS reads.
`timescale 1ns/1ps
module tb_tx_fifo_axis;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0, awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = 4'hF;
    logic          wvalid = 1'b0, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready = 1'b1;
    logic [DW-1:0] tdata;
    logic          tlast, tvalid, tready = 1'b0;
    logic          ovf_pin;

    tx_fifo_axis #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .overflow(ovf_pin)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as {tlast, data}, sticky overflow, pending responses
    logic [32:0] sq[$];
    logic [1:0]  bq[$];
    logic [31:0] rq[$];
    bit          m_ovf = 1'b0;
    int          n_cmp = 0, n_err = 0;
    int          beats = 0;
    int          tmode = 0;      // 0 low, 1 high, 2 toggle, 3 random, other = driven by main
    bit          rnd_resp = 1'b0;
    bit          hold_b = 1'b0;
    logic [31:0] last_rdata;
    int          pre;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_exp();
        int lvl;
        logic [31:0] s, l;
        lvl = sq.size();
        l = 32'(lvl);
        s = 32'h0;
        s[15:8] = l[7:0];
        s[2] = m_ovf;
        s[1] = (lvl == DEPTH);
        s[0] = (lvl == 0);
        return s;
    endfunction

    // Response/stream ready drivers
    always @(posedge clk) begin
        #1;
        if (hold_b) begin
            bready = 1'b0;
        end else if (rnd_resp) begin
            bready = ($urandom_range(0, 3) != 0);
        end else begin
            bready = 1'b1;
        end
        rready = rnd_resp ? ($urandom_range(0, 3) != 0) : 1'b1;
        case (tmode)
            0: tready = 1'b0;
            1: tready = 1'b1;
            2: tready = ~tready;
            3: tready = $urandom_range(0, 1);
            default: ;
        endcase
    end

    // Monitor: samples the state presented for the coming edge and updates the model
    always @(negedge clk) begin
        if (rst_n) begin
            pre = sq.size();
            check("tvalid", tvalid, (pre != 0));
            check("overflow_pin", ovf_pin, m_ovf);
            if (arvalid && arready) begin
                rq.push_back((araddr[3:2] == 2'd2) ? status_exp() : 32'h0);
            end
            if (tvalid && tready && pre != 0) begin
                check("beat", {tlast, tdata}, sq.pop_front());
                beats++;
            end
            if (awvalid && awready && wvalid && wready) begin
                case (awaddr[3:2])
                    2'd0, 2'd1: begin
                        if (pre == DEPTH) begin
                            m_ovf = 1'b1;
                            bq.push_back(2'b10);
                        end else begin
                            sq.push_back({awaddr[2], wdata});
                            bq.push_back(2'b00);
                        end
                    end
                    2'd3: begin
                        bq.push_back(2'b00);
                        if (wdata[0]) sq.delete();
                        if (wdata[1]) m_ovf = 1'b0;
                    end
                    default: bq.push_back(2'b00);
                endcase
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) check("bresp_unexpected", 1'b1, 1'b0);
                else check("bresp", bresp, bq.pop_front());
            end
            if (rvalid && rready) begin
                check("rresp", rresp, 2'b00);
                if (rq.size() == 0) check("rdata_unexpected", 1'b1, 1'b0);
                else check("rdata", rdata, rq.pop_front());
            end
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input bit skew);
        bit ok;
        @(posedge clk) #1;
        awaddr = addr; wdata = data; wstrb = 4'($urandom); awvalid = 1'b1;
        if (skew) begin
            @(negedge clk);
            check("lone_aw_waits", awready, 1'b0);
            @(posedge clk) #1;
        end
        wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = awready && wready;
        end
        if (!ok) check("aw_timeout", 1'b1, 1'b0);
        @(posedge clk) #1;
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bvalid && bready;
        end
        if (!ok) check("b_timeout", 1'b1, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] addr);
        bit ok;
        @(posedge clk) #1;
        araddr = addr; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) check("ar_timeout", 1'b1, 1'b0);
        @(posedge clk) #1;
        arvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = rvalid && rready;
        end
        if (!ok) check("r_timeout", 1'b1, 1'b0);
        last_rdata = rdata;
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = (sq.size() == 0);
        end
        if (!ok) check("drain_timeout", 1'b1, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {awready, wready, bvalid, bresp, arready, rvalid, rresp, tvalid, ovf_pin, rdata},
              64'h0);
    endtask

    initial begin
        int b0;
        logic [3:0] a;
        #2;
        check_reset_outputs("reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single word, one beat, STATUS empty afterwards
        tmode = 1;
        b0 = beats;
        axi_write(4'h0, 32'hA5A5_0001, 1'b0);
        repeat (3) @(negedge clk);
        check("single_beat_count", beats - b0, 1);
        axi_read(4'h8);
        check("status_after_single", last_rdata, 32'h0000_0001);

        // Framed burst held back, then released
        tmode = 0;
        for (int i = 0; i < 3; i++) axi_write(4'h0, 32'h1000_0000 + i, i[0]);
        axi_write(4'h4, 32'h1000_00FF, 1'b0);
        axi_read(4'h8);
        check("status_level4", last_rdata, 32'h0000_0400);
        tmode = 1;
        wait_empty();

        // Overflow: 17 writes into 16 entries, then clear
        tmode = 0;
        for (int i = 0; i < 17; i++) axi_write(4'h0, $urandom, 1'b0);
        axi_read(4'h8);
        check("status_full_ovf", last_rdata, 32'h0000_1006);
        check("overflow_set", ovf_pin, 1'b1);
        axi_write(4'hC, 32'h2, 1'b0);
        check("overflow_cleared", ovf_pin, 1'b0);

        // Full FIFO with a pop in the push cycle: push still rejected
        tmode = 9;
        @(posedge clk) #1;
        tready = 1'b1; awaddr = 4'h0; wdata = 32'hDEAD_BEEF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("full_pop_push_hs", awready, 1'b1);
        @(posedge clk) #1;
        tready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) @(negedge clk);
        axi_read(4'h8);
        check("status_full_pop", last_rdata, 32'h0000_0F04);
        axi_write(4'hC, 32'h2, 1'b0);

        // 40 words with toggling tready, across pointer wrap
        tmode = 2;
        for (int i = 0; i < 40; i++) axi_write({1'b0, 1'($urandom), 2'b00}, $urandom, 1'($urandom));
        tmode = 1;
        wait_empty();

        // Flush with an idle stream
        tmode = 0;
        for (int i = 0; i < 5; i++) axi_write(4'h0, $urandom, 1'b0);
        axi_write(4'hC, 32'h1, 1'b0);
        axi_read(4'h8);
        check("status_after_flush", last_rdata, 32'h0000_0001);

        // Randomized mix of register traffic
        tmode = 3;
        rnd_resp = 1'b1;
        for (int i = 0; i < 120; i++) begin
            a = {2'($urandom_range(0, 3)), 2'b00};
            if ($urandom_range(0, 3) == 0) begin
                axi_read(a);
            end else if (a == 4'hC) begin
                if ($urandom_range(0, 4) == 0) axi_write(a, 32'($urandom_range(0, 3)), 1'b0);
                else axi_write(4'h0, $urandom, 1'b0);
            end else begin
                axi_write(a, $urandom, 1'($urandom));
            end
            if (i % 40 == 20) tmode = 0;
            if (i % 40 == 39) tmode = 3;
        end
        rnd_resp = 1'b0;
        tmode = 1;
        wait_empty();

        // Asynchronous reset mid-stream with a B response pending
        tmode = 3;
        for (int i = 0; i < 4; i++) axi_write(4'h0, $urandom, 1'b0);
        hold_b = 1'b1;
        @(posedge clk) #1;
        awaddr = 4'h4; wdata = 32'h5555_AAAA; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk) #1;
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 4'h8;
        #1;
        check("bvalid_pending", bvalid, 1'b1);
        #1;
        rst_n = 1'b0;
        sq.delete(); bq.delete(); rq.delete(); m_ovf = 1'b0;
        #1;
        check_reset_outputs("async_reset_outputs");
        arvalid = 1'b0;
        hold_b = 1'b0;
        tmode = 1;
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset_outputs");
        rst_n = 1'b1;
        b0 = beats;
        axi_write(4'h0, 32'hA5A5_0001, 1'b0);
        repeat (3) @(negedge clk);
        check("post_reset_beat_count", beats - b0, 1);
        axi_read(4'h8);
        check("post_reset_status", last_rdata, 32'h0000_0001);

        repeat (3) @(negedge clk);
        check("bq_drained", bq.size(), 0);
        check("rq_drained", rq.size(), 0);
        check("sq_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
